// File: rtl/hex_print_streamer.sv
// ---------------------------------------------------------------------------
// hex_print_streamer
//
// Captures 32-bit words posted by the CPU to the print region, queues them
// in a small word FIFO and streams each one out as eight lowercase hex ASCII
// characters followed by a terminator byte, one byte per handshake, towards
// the UART TX buffer.
//
// Serializer states:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | nothing being sent; pops the FIFO as soon as it is non-empty
//   ST_HEX  | presenting hex character for the top nibble of r_shift
//   ST_NL   | presenting the terminator; pops the next word on handshake
//
// Ports:
//   clk_i           system clock, rising edge
//   rst_i           synchronous active-high reset
//   write_i         one-cycle posted write strobe
//   write_data_i    word to print
//   write_ready_o   FIFO not full (registered)
//   byte_valid_o    byte_o holds a valid character
//   byte_o          ASCII character
//   byte_ready_i    downstream accepts byte_o this cycle
//   level_o         words waiting in the FIFO (excludes the one in flight)
//   dropped_count_o writes lost to a full FIFO, saturating
//   idle_o          FIFO empty and serializer idle
// ---------------------------------------------------------------------------
module hex_print_streamer #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [7:0]  NEWLINE    = 8'h0A
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            write_i,
    input  logic [31:0]                     write_data_i,
    output logic                            write_ready_o,
    output logic                            byte_valid_o,
    output logic [7:0]                      byte_o,
    input  logic                            byte_ready_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] level_o,
    output logic [15:0]                     dropped_count_o,
    output logic                            idle_o
);

    localparam int unsigned   PW         = $clog2(FIFO_DEPTH);
    localparam int unsigned   LW         = $clog2(FIFO_DEPTH + 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEX  = 2'd1,
        ST_NL   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [LW-1:0] w_level_nxt;
    logic          r_write_ready;
    logic [15:0]   r_dropped;
    logic [31:0]   r_shift;
    logic [2:0]    r_nib_cnt;

    logic          w_fifo_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic          w_byte_valid;
    logic          w_handshake;
    logic [7:0]    w_byte;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h57 + {4'h0, nib};
    endfunction

    assign w_fifo_empty = (r_level == '0);
    assign w_byte_valid = (r_state != ST_IDLE);
    assign w_handshake  = w_byte_valid & byte_ready_i;

    // Producers are never stalled: a write while full is simply counted.
    assign w_push = write_i & r_write_ready;
    assign w_drop = write_i & ~r_write_ready;

    // Next-state logic; w_pop marks the cycle a word moves FIFO -> r_shift.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_HEX;
                end
            end
            ST_HEX: begin
                if (w_handshake && (r_nib_cnt == 3'd7)) begin
                    w_state_nxt = ST_NL;
                end
            end
            ST_NL: begin
                if (w_handshake) begin
                    // Chain straight into the next word so back-to-back
                    // words leave no idle cycle on the byte stream.
                    if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_HEX;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_byte = 8'h00;
        case (r_state)
            ST_HEX:  w_byte = hex_ascii(r_shift[31:28]);
            ST_NL:   w_byte = NEWLINE;
            default: w_byte = 8'h00;
        endcase
    end

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + 1'b1;
            2'b01:   w_level_nxt = r_level - 1'b1;
            default: w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_write_ready <= 1'b1;
            r_dropped     <= 16'h0000;
            r_shift       <= 32'h0;
            r_nib_cnt     <= 3'd0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= 32'h0;
            end
        end else begin
            r_state       <= w_state_nxt;
            r_level       <= w_level_nxt;
            // Full flag is computed from the next occupancy so it is a
            // plain flop output, aligned with level_o.
            r_write_ready <= (w_level_nxt != FULL_LEVEL);

            if (w_push) begin
                r_mem[r_wr_ptr] <= write_data_i;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end

            if (w_pop) begin
                r_shift   <= r_mem[r_rd_ptr];
                r_nib_cnt <= 3'd0;
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end else if ((r_state == ST_HEX) && w_handshake) begin
                r_shift   <= {r_shift[27:0], 4'h0};
                r_nib_cnt <= r_nib_cnt + 3'd1;
            end

            if (w_drop && (r_dropped != 16'hFFFF)) begin
                r_dropped <= r_dropped + 16'd1;
            end
        end
    end

    assign write_ready_o   = r_write_ready;
    assign byte_valid_o    = w_byte_valid;
    assign byte_o          = w_byte;
    assign level_o         = r_level;
    assign dropped_count_o = r_dropped;
    assign idle_o          = w_fifo_empty & (r_state == ST_IDLE);

endmodule

// File: tb/tb_hex_print_streamer.sv
module tb_hex_print_streamer;

    localparam int DEPTH = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        write_i;
    logic [31:0] write_data_i;
    logic        write_ready_o;
    logic        byte_valid_o;
    logic [7:0]  byte_o;
    logic        byte_ready_i;
    logic [3:0]  level_o;
    logic [15:0] dropped_count_o;
    logic        idle_o;

    hex_print_streamer #(.FIFO_DEPTH(DEPTH), .NEWLINE(8'h0A)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .write_i         (write_i),
        .write_data_i    (write_data_i),
        .write_ready_o   (write_ready_o),
        .byte_valid_o    (byte_valid_o),
        .byte_o          (byte_o),
        .byte_ready_i    (byte_ready_i),
        .level_o         (level_o),
        .dropped_count_o (dropped_count_o),
        .idle_o          (idle_o)
    );

    always #5 clk_i = ~clk_i;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        string hd;
        hd = "0123456789abcdef";
        return hd[n];
    endfunction

    // Reference model: a queue of waiting words and a queue of characters
    // still owed to the UART for the word in flight.
    logic [31:0] m_fifo[$];
    logic [7:0]  m_pend[$];
    int          m_drop = 0;
    bit          m_on   = 0;

    logic [31:0] m_w;
    bit          m_hs, m_pop, m_can_push;

    always @(posedge clk_i) begin
        cyc++;
        if (rst_i) begin
            m_fifo.delete();
            m_pend.delete();
            m_drop = 0;
            m_on   = 1;
        end else if (m_on) begin
            m_hs       = (m_pend.size() > 0) && byte_ready_i;
            m_pop      = (m_fifo.size() > 0) && ((m_pend.size() == 0) || (m_hs && m_pend.size() == 1));
            m_can_push = m_fifo.size() < DEPTH;
            if (m_hs) void'(m_pend.pop_front());
            if (m_pop) begin
                m_w = m_fifo.pop_front();
                for (int k = 7; k >= 0; k--) m_pend.push_back(hexc(4'((m_w >> (4 * k)) & 32'hF)));
                m_pend.push_back(8'h0A);
            end
            if (write_i) begin
                if (m_can_push) m_fifo.push_back(write_data_i);
                else if (m_drop < 65535) m_drop++;
            end
        end
    end

    always @(negedge clk_i) begin
        if (m_on) begin
            chk("byte_valid", byte_valid_o, m_pend.size() > 0);
            chk("byte", byte_o, (m_pend.size() > 0) ? m_pend[0] : 8'h00);
            chk("level", level_o, m_fifo.size());
            chk("write_ready", write_ready_o, m_fifo.size() != DEPTH);
            chk("dropped", dropped_count_o, m_drop);
            chk("idle", idle_o, (m_fifo.size() == 0) && (m_pend.size() == 0));
        end
    end

    // Record every byte the UART side actually takes, with its cycle stamp.
    logic [7:0] cap_b[$];
    int         cap_t[$];
    always @(negedge clk_i) begin
        if (!rst_i && byte_valid_o === 1'b1 && byte_ready_i === 1'b1) begin
            cap_b.push_back(byte_o);
            cap_t.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [31:0] d);
        write_i      = 1'b1;
        write_data_i = d;
        tick();
        write_i      = 1'b0;
    endtask

    task automatic cap_clear();
        cap_b.delete();
        cap_t.delete();
    endtask

    task automatic wait_cap(input string name, input int n, input int budget);
        int c = 0;
        while (cap_b.size() < n && c < budget) begin
            tick();
            c++;
        end
        if (cap_b.size() < n) chk({name, "_timeout"}, cap_b.size(), n);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int c = 0;
        while (idle_o !== 1'b1 && c < budget) begin
            tick();
            c++;
        end
        chk({name, "_idle"}, idle_o, 1'b1);
    endtask

    task automatic cmp_str(input string name, input string s);
        chk({name, "_len"}, cap_b.size(), s.len());
        for (int i = 0; i < s.len(); i++) begin
            if (i < cap_b.size()) chk(name, cap_b[i], s[i]);
        end
    endtask

    task automatic cmp_q(input string name, input logic [7:0] q[$]);
        chk({name, "_len"}, cap_b.size(), q.size());
        for (int i = 0; i < q.size(); i++) begin
            if (i < cap_b.size()) chk(name, cap_b[i], q[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0]  exp_q[$];
    logic [31:0] wd;
    string       s;

    initial begin
        rst_i        = 1'b1;
        write_i      = 1'b0;
        write_data_i = 32'h0;
        byte_ready_i = 1'b0;
        tick();
        tick();
        chk("rst_byte_valid", byte_valid_o, 1'b0);
        chk("rst_byte", byte_o, 8'h00);
        chk("rst_write_ready", write_ready_o, 1'b1);
        chk("rst_level", level_o, 4'd0);
        chk("rst_dropped", dropped_count_o, 16'h0);
        chk("rst_idle", idle_o, 1'b1);
        rst_i = 1'b0;
        tick();

        // Single word with latency pin
        byte_ready_i = 1'b1;
        cap_clear();
        wr(32'hDEADBEEF);
        chk("lat_level", level_o, 4'd1);
        chk("lat_valid_early", byte_valid_o, 1'b0);
        tick();
        chk("lat_valid", byte_valid_o, 1'b1);
        chk("lat_first_byte", byte_o, 8'h64);
        wait_cap("single", 9, 40);
        tick();
        cmp_str("single", "deadbeef\n");
        chk("single_idle", idle_o, 1'b1);

        // Nibble mapping, back to back with no bubble
        cap_clear();
        wr(32'h0123ABCD);
        wr(32'h00000000);
        wait_cap("nibble", 18, 60);
        cmp_str("nibble", "0123abcd\n00000000\n");
        for (int i = 1; i < 18; i++) begin
            if (i < cap_t.size()) chk("nibble_gap", cap_t[i] - cap_t[i-1], 1);
        end
        wait_idle("nibble", 20);

        // Backpressure on the third character
        cap_clear();
        wr(32'h89ABCDEF);
        wait_cap("bp", 2, 20);
        byte_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_byte", byte_o, 8'h61);
            chk("bp_hold_valid", byte_valid_o, 1'b1);
            tick();
        end
        byte_ready_i = 1'b1;
        wait_cap("bp", 9, 40);
        cmp_str("bp", "89abcdef\n");
        wait_idle("bp", 20);

        // Overflow: 12 writes with UART stalled
        byte_ready_i = 1'b0;
        for (int i = 0; i < 12; i++) wr(32'(i));
        chk("ovf_level", level_o, 4'd8);
        chk("ovf_write_ready", write_ready_o, 1'b0);
        chk("ovf_dropped", dropped_count_o, 16'd3);
        cap_clear();
        byte_ready_i = 1'b1;
        wait_cap("ovf", 81, 200);
        s = "";
        for (int x = 0; x <= 8; x++) s = {s, $sformatf("0000000%0d\n", x)};
        cmp_str("ovf", s);
        wait_idle("ovf", 20);

        // Reset clears the drop count before the wrap-around run
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("clr_dropped", dropped_count_o, 16'd0);

        // Wrap-around: 40 distinct words, one every 9 cycles
        cap_clear();
        exp_q.delete();
        for (int i = 0; i < 40; i++) begin
            wd = {8'(i), 24'($urandom)};
            for (int k = 7; k >= 0; k--) exp_q.push_back(hexc(4'((wd >> (4 * k)) & 32'hF)));
            exp_q.push_back(8'h0A);
            wr(wd);
            repeat (8) tick();
        end
        wait_cap("wrap", 360, 100);
        cmp_q("wrap", exp_q);
        chk("wrap_dropped", dropped_count_o, 16'd0);
        wait_idle("wrap", 20);

        // Reset in the middle of a word with more queued
        cap_clear();
        wr(32'hCAFEF00D);
        wr(32'h11111111);
        wr(32'h22222222);
        wait_cap("rstmid", 4, 20);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rstmid_valid", byte_valid_o, 1'b0);
        chk("rstmid_level", level_o, 4'd0);
        cap_clear();
        repeat (20) tick();
        chk("rstmid_no_bytes", cap_b.size(), 0);
        chk("rstmid_dropped", dropped_count_o, 16'd0);
        wr(32'h00000001);
        wait_cap("rstmid_after", 9, 40);
        cmp_str("rstmid_after", "00000001\n");
        wait_idle("rstmid_after", 20);

        // Random traffic and random backpressure against the model
        for (int i = 0; i < 600; i++) begin
            write_i      = ($urandom_range(0, 2) == 0);
            write_data_i = $urandom;
            byte_ready_i = $urandom_range(0, 1) == 1;
            rst_i        = ($urandom_range(0, 299) == 0);
            tick();
        end
        write_i      = 1'b0;
        rst_i        = 1'b0;
        byte_ready_i = 1'b1;
        wait_idle("random", 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
